// File: rtl/debounce_bank_if.sv
// Button-bank bundle: raw pins and counter clear in,
// debounced levels, strobes and press counters out.
interface debounce_bank_if #(
   parameter int N_CH    = 4,
   parameter int PRESS_W = 8
);
   logic [N_CH-1:0]         button;
   logic                    clr_count;
   logic [N_CH-1:0]         out;
   logic [N_CH-1:0]         press;
   logic [N_CH-1:0]         rel;
   logic [N_CH*PRESS_W-1:0] press_count;

   modport master (
      output button,
      output clr_count,
      input  out,
      input  press,
      input  rel,
      input  press_count
   );

   modport slave (
      input  button,
      input  clr_count,
      output out,
      output press,
      output rel,
      output press_count
   );
endinterface

// File: rtl/debounce_bank.sv
// Multi-channel button conditioner: 2-flop sync, stability
// qualification, press/release strobes and press counters.
module debounce_bank #(
   parameter int N_CH          = 4,
   parameter int STABLE_CYCLES = 3000000,
   parameter int CNT_W         = 22,
   parameter int PRESS_W       = 8,
   parameter int ACTIVE_LOW    = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   debounce_bank_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST =
      CNT_W'(STABLE_CYCLES - 1);

   logic [N_CH-1:0]    pin;
   logic [N_CH-1:0]    s1;
   logic [N_CH-1:0]    s2;
   logic [N_CH-1:0]    lvl;
   logic [N_CH-1:0]    press_q;
   logic [N_CH-1:0]    rel_q;
   logic [CNT_W-1:0]   cnt  [N_CH];
   logic [PRESS_W-1:0] pcnt [N_CH];

   assign pin = (ACTIVE_LOW != 0) ? ~bus.button : bus.button;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1      <= '0;
         s2      <= '0;
         lvl     <= '0;
         press_q <= '0;
         rel_q   <= '0;
         for (int i = 0; i < N_CH; i++) begin
            cnt[i]  <= '0;
            pcnt[i] <= '0;
         end
      end else begin
         s1      <= pin;
         s2      <= s1;
         press_q <= '0;
         rel_q   <= '0;
         for (int i = 0; i < N_CH; i++) begin
            // any return to the accepted level restarts qualification
            if (s2[i] == lvl[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == LAST) begin
               lvl[i]     <= s2[i];
               cnt[i]     <= '0;
               press_q[i] <= s2[i];
               rel_q[i]   <= ~s2[i];
               if (s2[i])
                  pcnt[i] <= pcnt[i] + PRESS_W'(1);
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
            if (bus.clr_count)
               pcnt[i] <= '0;
         end
      end
   end

   assign bus.out   = lvl;
   assign bus.press = press_q;
   assign bus.rel   = rel_q;

   for (genvar g = 0; g < N_CH; g++) begin : g_cnt
      assign bus.press_count[g*PRESS_W +: PRESS_W] = pcnt[g];
   end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: one active-high bank and
// one active-low bank, STABLE_CYCLES=8, PRESS_W=4.
module tb_debounce_bank;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   logic bad;

   always #5 clk = ~clk;

   debounce_bank_if #(.N_CH(4), .PRESS_W(4)) a ();
   debounce_bank_if #(.N_CH(4), .PRESS_W(4)) b ();

   debounce_bank #(
      .N_CH(4), .STABLE_CYCLES(8), .CNT_W(4),
      .PRESS_W(4), .ACTIVE_LOW(0)
   ) u_hi (
      .clk(clk), .rst_n(rst_n), .bus(a)
   );

   debounce_bank #(
      .N_CH(4), .STABLE_CYCLES(8), .CNT_W(4),
      .PRESS_W(4), .ACTIVE_LOW(1)
   ) u_lo (
      .clk(clk), .rst_n(rst_n), .bus(b)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n       = 1'b0;
      a.button    = '0;
      a.clr_count = 1'b0;
      b.button    = '1;
      b.clr_count = 1'b0;
      #3;
      check("rst_out",   a.out, 0);
      check("rst_press", a.press, 0);
      check("rst_rel",   a.rel, 0);
      check("rst_cnt",   a.press_count, 0);
      check("rst_lo_out", b.out, 0);
      tick(2);
      rst_n = 1'b1;
      tick(3);

      // all channels pressed, then reset asynchronously
      a.button = 4'hF;
      tick(10);
      check("pre_rst_out", a.out, 4'hF);
      check("pre_rst_press", a.press, 4'hF);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_out", a.out, 0);
      check("async_rst_press", a.press, 0);
      check("async_rst_cnt", a.press_count, 0);
      tick(1);
      rst_n = 1'b1;
      tick(9);
      check("requal_e8", a.out, 0);
      tick(1);
      check("requal_e9", a.out, 4'hF);
      check("requal_press", a.press, 4'hF);
      check("requal_cnt", a.press_count, 16'h1111);
      tick(1);
      check("requal_press_1cyc", a.press, 0);
      a.button = 4'h0;
      tick(10);
      check("all_rel_out", a.out, 0);
      check("all_rel_strobe", a.rel, 4'hF);
      check("all_rel_cnt", a.press_count, 16'h1111);
      tick(1);

      // clean press on ch0
      a.button[0] = 1'b1;
      tick(9);
      check("ch0_e8", a.out, 0);
      tick(1);
      check("ch0_e9", a.out, 4'h1);
      check("ch0_press", a.press, 4'h1);
      check("ch0_cnt", a.press_count, 16'h1112);
      tick(1);
      check("ch0_press_1cyc", a.press, 0);
      tick(10);
      check("ch0_hold", a.out, 4'h1);
      a.button[0] = 1'b0;
      tick(10);
      check("ch0_rel", a.rel, 4'h1);
      check("ch0_rel_out", a.out, 0);
      tick(1);
      check("ch0_rel_cnt", a.press_count, 16'h1112);

      // bouncing ch1
      bad = 1'b0;
      for (int k = 0; k < 10; k++) begin
         a.button[1] = (k % 2 == 0);
         for (int j = 0; j < 3; j++) begin
            tick(1);
            if (a.out[1] || a.press[1]) bad = 1'b1;
         end
      end
      check("ch1_bounce_quiet", bad, 0);
      a.button[1] = 1'b1;
      tick(9);
      check("ch1_e8", a.out, 0);
      tick(1);
      check("ch1_e9", a.out, 4'h2);
      check("ch1_cnt", a.press_count, 16'h1122);
      a.button[1] = 1'b0;
      tick(12);

      // ch2 glitch of 7 cycles, then 8
      a.button[2] = 1'b1;
      tick(7);
      a.button[2] = 1'b0;
      bad = 1'b0;
      for (int j = 0; j < 12; j++) begin
         tick(1);
         if (a.out[2] || a.press[2]) bad = 1'b1;
      end
      check("ch2_glitch_quiet", bad, 0);
      check("ch2_glitch_cnt", a.press_count, 16'h1122);
      a.button[2] = 1'b1;
      tick(8);
      a.button[2] = 1'b0;
      tick(2);
      check("ch2_8cyc_out", a.out, 4'h4);
      check("ch2_8cyc_cnt", a.press_count, 16'h1222);
      tick(12);
      check("ch2_8cyc_fall", a.out, 0);

      // clear, wrap, clear beating a press
      a.clr_count = 1'b1;
      tick(1);
      a.clr_count = 1'b0;
      check("clr_all", a.press_count, 0);
      for (int p = 1; p <= 16; p++) begin
         a.button[3] = 1'b1;
         tick(10);
         a.button[3] = 1'b0;
         tick(11);
         if (p == 15) check("ch3_cnt15", a.press_count, 16'hF000);
      end
      check("ch3_wrap", a.press_count, 0);
      a.button[3] = 1'b1;
      tick(9);
      a.clr_count = 1'b1;
      tick(1);
      a.clr_count = 1'b0;
      check("clr_win_press", a.press, 4'h8);
      check("clr_win_out", a.out, 4'h8);
      check("clr_win_cnt", a.press_count, 0);
      a.button[3] = 1'b0;
      tick(12);

      // active-low bank, idle high for the whole run so far
      check("lo_idle_out", b.out, 0);
      check("lo_idle_cnt", b.press_count, 0);
      b.button[0] = 1'b0;
      tick(9);
      check("lo_e8", b.out, 0);
      tick(1);
      check("lo_e9", b.out, 4'h1);
      check("lo_press", b.press, 4'h1);
      check("lo_cnt", b.press_count, 16'h0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel push-button conditioner: each channel synchronises a raw asynchronous button input, accepts a level change only once it has held steady for a programmable number of clock cycles, and produces a clean level, single-cycle press/release strobes and a per-channel press counter. It sits between the board switch pins and the user logic, replacing single-button debouncers. It also provides a deterministic reset state and cycle-exact latency.

## Interface

- N_CH, 4, number of independent button channels (>=1)
- STABLE_CYCLES, 3_000_000, consecutive cycles a new level must persist before acceptance (30 ms at 100 MHz); >=2
- CNT_W, 22, stability counter width; must satisfy 2^CNT_W > STABLE_CYCLES-1
- PRESS_W, 8, width of each press counter
- ACTIVE_LOW, 0, 1 = raw input reads 0 when pressed; inverted before synchronisation

- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- button  input  N_CH  raw, asynchronous, bouncing switch inputs
- clr_count  input  1  synchronous clear of all press counters
- out  output  N_CH  debounced level, 1 = pressed
- press  output  N_CH  one-cycle strobe on accepted 0->1 of out
- release  output  N_CH  one-cycle strobe on accepted 1->0 of out
- press_count  output  N_CH*PRESS_W  per-channel press counters, channel i at bits [i*PRESS_W +: PRESS_W]

## Operation

- Per channel, identical and independent logic; no shared state except clr_count.
- Polarity: pin value p = button[i] ^ ACTIVE_LOW (1 = pressed).
- Synchroniser: two flops, s1 <= p, s2 <= s1. Only s2 feeds downstream logic.
- Stability counter cnt (CNT_W bits), per edge:
  - s2 == out: cnt <= 0.
  - s2 != out and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - s2 != out and cnt == STABLE_CYCLES-1: out <= s2, cnt <= 0.
- Any bounce (s2 returning to out) before acceptance restarts the count from 0; no partial credit.
- Strobes: registered; press = 1 for exactly the cycle after an edge where out went 0->1, release likewise for 1->0; otherwise 0.
- Press counter: increments by 1 (modulo 2^PRESS_W, wraps to 0) on the same edge out goes 0->1.
- clr_count = 1: all press_count <= 0 at that edge; clear wins over a simultaneous increment (that press is not counted, press strobe still fires).
- Release transitions never change press_count.

## Timing

- Reset (rst_n low, asynchronous, no clock needed): s1, s2, out, cnt, press, release, press_count all 0. Release of rst_n must be synchronous to clk at system level; block does not re-synchronise it.
- Reset asserted mid-count: count discarded, out forced 0; a channel held pressed through reset must complete a full STABLE_CYCLES qualification after reset release.
- Latency: if p takes a new steady value first sampled by s1 at edge E0, s2 holds it after E1, out changes at edge E(STABLE_CYCLES+1), press/release valid during the following cycle, press_count updated at that same edge.
- Glitch shorter than STABLE_CYCLES cycles at s2: out, strobes, counter unchanged.
- Strobes never coincide with each other on one channel; minimum spacing between out changes is STABLE_CYCLES cycles.
- Counter wrap: 2^PRESS_W-1 + one press -> 0, no flag.

## Test plan

Simulate with N_CH=4, STABLE_CYCLES=8, PRESS_W=4, ACTIVE_LOW=0.

- Reset: drive rst_n=0 with button=4'hF mid-run -> all outputs 0 immediately, without a clock edge; after release, out[i] rises exactly 9 edges after the first edge sampling 1.
- Clean press ch0: button[0] 0->1 held 20 cycles -> out[0]=1 at edge E9, press[0] high exactly one cycle, press_count ch0 = 1, other channels unchanged.
- Bounce ch1: toggle button[1] every 3 cycles for 30 cycles then hold 1 -> no out/press during toggling; out[1]=1 nine edges after final stable sampling, press_count ch1 = 1.
- Glitch: button[2] high for 7 cycles then low -> out[2], press[2], press_count ch2 stay 0; 8 cycles high -> out[2] asserts.
- Wrap and clear: 16 clean presses on ch3 -> press_count ch3 returns to 0; then press coinciding with clr_count=1 on the acceptance edge -> press[3] fires, press_count ch3 = 0.
- ACTIVE_LOW=1 rerun: button idle 1 after reset -> out stays 0; driving 0 for 8+ cycles -> out=1, press strobe, count increments.
